instr_cycle_sequencer: RTL and testbench
========================================

Name: instr_cycle_sequencer

Overview:
Four-phase instruction-cycle controller for the 8-bit PIC-style core. It replaces the half-frequency dividers and AND-gated phase clocks with one synchronous FSM. The FSM emits single-cycle enable strobes for fetch, operand read, ALU execute and write-back. It also handles branch/skip pipeline flushes, run/halt, single-step, and a retired-instruction counter. The strobes drive the PC, instruction memory, ALU, W register and file register bank as clock enables.

Parameters:
RST_WAIT, 2, idle clk cycles after reset release before the first Q1
CNT_W, 16, width of the retired-instruction counter

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
run_en  in  1  1 = free-run; 0 = halt at the next instruction boundary
step_req  in  1  single-cycle pulse; while halted, runs exactly one instruction cycle
branch_taken  in  1  from decoder/MUX2 flag path; sampled only in Q3
skip_taken  in  1  bit-test/decrement-skip result; sampled only in Q3
q_phase  out  2  current phase: 0=Q1, 1=Q2, 2=Q3, 3=Q4 (0 when not running)
inst_fetch  out  1  Q1 strobe: instruction memory read
data_fetch  out  1  Q2 strobe: file register / literal operand read
alu_exec  out  1  Q3 strobe: ALU evaluate, flags update
write_back  out  1  Q4 strobe: W or F write
pc_inc  out  1  Q4 strobe: PC advance (or load on branch)
nop_cycle  out  1  high for all of a flushed instruction cycle
halted  out  1  sequencer parked in HALT
retired  out  CNT_W  count of completed, non-flushed instruction cycles

Behaviour:
- Reset (asynchronous, active-low): state=WAIT, wait counter=0, all strobes 0, q_phase=0, nop_cycle=0, halted=0, retired=0, flush flag=0.
- States: WAIT, Q1, Q2, Q3, Q4, HALT.
- WAIT: counts RST_WAIT clks, then goes to Q1 if run_en=1, else HALT.
- Phases: Q1→Q2→Q3→Q4, one clk each. Strobes are registered, high exactly while in the matching state. A full instruction cycle is 4 clks.
- Exit from Q4:
  - run_en=1 → Q1.
  - run_en=0 → HALT. The current cycle always completes; halting is never mid-cycle.
- HALT: halted=1, all strobes 0. Exits to Q1 when run_en=1 or step_req=1 (both high → Q1).
  - step_req cycle: after its Q4, returns to HALT unless run_en is 1.
  - step_req outside HALT is ignored. It is not queued.
- Flush:
  - In Q3 of a non-flushed cycle, branch_taken|skip_taken sets the flush flag.
  - The next instruction cycle has nop_cycle=1 for all 4 phases.
  - In that cycle, inst_fetch and pc_inc still pulse. data_fetch, alu_exec and write_back are forced 0.
  - The flag clears at the end of the flushed Q4.
  - branch_taken/skip_taken are ignored during a flushed cycle (no back-to-back flush).
- retired: increments by 1 at the end of every Q4 with nop_cycle=0. Wraps from 2^CNT_W-1 to 0 with no sticky flag.
- Flush flag survives HALT: a halt between a branch and its flush cycle still executes the flush cycle first on resume.
- Reset mid-cycle: immediate return to reset values. No partial write_back is emitted.
- q_phase in WAIT/HALT is 0, qualified by halted/strobes.

Decomposition:
- Shared package cpu_pkg holds:
  - state enum: WAIT, Q1, Q2, Q3, Q4, HALT
  - phase encoding constants: PH_Q1..PH_Q4
  - default RST_WAIT value
- Optional sub-module: retire_counter (CNT_W-bit enable counter with async active-low reset), reused by later performance counters.

Test Plan:
- Reset release, run_en=1, RST_WAIT=2 → first inst_fetch 3 clks after reset rises. Strobes then repeat with period 4 (Q1..Q4). After 5 cycles (20 clks), retired=5.
- branch_taken=1 in Q3 of cycle 2 → cycle 3 has nop_cycle=1, inst_fetch/pc_inc pulse, no data_fetch/alu_exec/write_back. retired=2 after cycle 3 and 3 after cycle 4.
- run_en dropped during Q2 → the cycle finishes through Q4 with write_back, then halted=1 and strobes stay 0 for 20 clks.
- While halted, pulse step_req once → exactly one Q1..Q4 sequence, retired increments by 1, halted=1 again. A second step_req during Q2 is ignored.
- Branch in last cycle before halt, then step_req → stepped cycle is the flush cycle (nop_cycle=1, retired unchanged).
- reset asserted low during Q3 → all outputs 0 within the same clk (asynchronous). After release, the WAIT→Q1 sequence restarts with retired=0. Preload to 16'hFFFF via force → next retire wraps to 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction-cycle sequencer and its helpers:
// FSM state encoding, Q-phase codes and the default post-reset wait length.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_WAIT = 3'd0,
    ST_Q1   = 3'd1,
    ST_Q2   = 3'd2,
    ST_Q3   = 3'd3,
    ST_Q4   = 3'd4,
    ST_HALT = 3'd5
  } state_e;

  localparam logic [1:0] PH_Q1 = 2'd0;
  localparam logic [1:0] PH_Q2 = 2'd1;
  localparam logic [1:0] PH_Q3 = 2'd2;
  localparam logic [1:0] PH_Q4 = 2'd3;

  localparam int RST_WAIT_DEF = 2;

  // Phase code shown on q_phase for a given state; WAIT/HALT read as 0.
  function automatic logic [1:0] phase_of(input state_e st);
    logic [1:0] ph;
    case (st)
      ST_Q1:   ph = PH_Q1;
      ST_Q2:   ph = PH_Q2;
      ST_Q3:   ph = PH_Q3;
      ST_Q4:   ph = PH_Q4;
      default: ph = 2'd0;
    endcase
    return ph;
  endfunction

endpackage

// File: rtl/retire_counter.sv
// Free-running enable counter with asynchronous active-low reset.
// Wraps silently at 2^CNT_W-1; reused by the performance counters.
module retire_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  // Count one per enabled clock; natural modulo wrap, no overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + CNT_W'(1'b1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/instr_cycle_sequencer.sv
// Four-phase (Q1..Q4) instruction-cycle controller. One FSM produces
// registered single-cycle enables for fetch, operand read, execute and
// write-back, and handles run/halt, single-step, branch/skip flush cycles
// and the retired-instruction count.
module instr_cycle_sequencer
  import cpu_pkg::*;
#(
  parameter int RST_WAIT = RST_WAIT_DEF,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_en,
  input  logic             step_req,
  input  logic             branch_taken,
  input  logic             skip_taken,
  output logic [1:0]       q_phase,
  output logic             inst_fetch,
  output logic             data_fetch,
  output logic             alu_exec,
  output logic             write_back,
  output logic             pc_inc,
  output logic             nop_cycle,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  localparam int WAIT_W = (RST_WAIT < 1) ? 1 : $clog2(RST_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RST_WAIT);

  state_e            r_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_flush;

  state_e            w_state_nxt;
  logic [WAIT_W-1:0] w_wait_nxt;
  logic              w_flush_nxt;
  logic              w_nop_nxt;
  logic              w_retire_en;

  // Next-state logic: post-reset wait, the Q1..Q4 ring, halt and resume.
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    case (r_state)
      ST_WAIT: begin
        if (r_wait_cnt == WAIT_LAST) begin
          w_state_nxt = run_en ? ST_Q1 : ST_HALT;
        end else begin
          w_wait_nxt = r_wait_cnt + WAIT_W'(1'b1);
        end
      end
      ST_Q1:   w_state_nxt = ST_Q2;
      ST_Q2:   w_state_nxt = ST_Q3;
      ST_Q3:   w_state_nxt = ST_Q4;
      ST_Q4:   w_state_nxt = run_en ? ST_Q1 : ST_HALT;
      ST_HALT: w_state_nxt = (run_en | step_req) ? ST_Q1 : ST_HALT;
      default: w_state_nxt = ST_WAIT;
    endcase
  end

  // Pending-flush flag: armed by a branch/skip in Q3 of a real cycle,
  // cleared once the flushed cycle's Q4 completes; held across HALT.
  always_comb begin
    if ((r_state == ST_Q3) && !nop_cycle && (branch_taken | skip_taken)) begin
      w_flush_nxt = 1'b1;
    end else if ((r_state == ST_Q4) && nop_cycle) begin
      w_flush_nxt = 1'b0;
    end else begin
      w_flush_nxt = r_flush;
    end
  end

  // A cycle is flushed if the flag is pending when its Q1 starts; the
  // marking then holds through Q4.
  always_comb begin
    case (w_state_nxt)
      ST_Q1:               w_nop_nxt = w_flush_nxt;
      ST_Q2, ST_Q3, ST_Q4: w_nop_nxt = nop_cycle;
      default:             w_nop_nxt = 1'b0;
    endcase
  end

  assign w_retire_en = (r_state == ST_Q4) && !nop_cycle;

  // State, wait counter and flush flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_WAIT;
      r_wait_cnt <= '0;
      r_flush    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_flush    <= w_flush_nxt;
    end
  end

  // Registered strobes decoded from the next state, so each is high exactly
  // while the FSM sits in its phase; flushed cycles keep only fetch/PC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_phase    <= 2'd0;
      inst_fetch <= 1'b0;
      data_fetch <= 1'b0;
      alu_exec   <= 1'b0;
      write_back <= 1'b0;
      pc_inc     <= 1'b0;
      nop_cycle  <= 1'b0;
      halted     <= 1'b0;
    end else begin
      q_phase    <= phase_of(w_state_nxt);
      inst_fetch <= (w_state_nxt == ST_Q1);
      data_fetch <= (w_state_nxt == ST_Q2) && !w_nop_nxt;
      alu_exec   <= (w_state_nxt == ST_Q3) && !w_nop_nxt;
      write_back <= (w_state_nxt == ST_Q4) && !w_nop_nxt;
      pc_inc     <= (w_state_nxt == ST_Q4);
      nop_cycle  <= w_nop_nxt;
      halted     <= (w_state_nxt == ST_HALT);
    end
  end

  retire_counter #(
    .CNT_W (CNT_W)
  ) u_retire (
    .clk     (clk),
    .rst_n   (reset),
    .i_en    (w_retire_en),
    .o_count (retired)
  );

endmodule

// File: tb/tb_instr_cycle_sequencer.sv
// Self-checking bench for instr_cycle_sequencer: a table of run-mode
// instruction cycles plus hand-written halt/step/flush/reset/wrap sequences.
// Every expected output word is queued before its clock edge and compared
// on the following falling edge.
module tb_instr_cycle_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        run_en;
  logic        step_req;
  logic        branch_taken;
  logic        skip_taken;
  logic [1:0]  q_phase;
  logic        inst_fetch;
  logic        data_fetch;
  logic        alu_exec;
  logic        write_back;
  logic        pc_inc;
  logic        nop_cycle;
  logic        halted;
  logic [15:0] retired;

  always #5 clk = ~clk;

  instr_cycle_sequencer #(
    .RST_WAIT (2),
    .CNT_W    (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .run_en       (run_en),
    .step_req     (step_req),
    .branch_taken (branch_taken),
    .skip_taken   (skip_taken),
    .q_phase      (q_phase),
    .inst_fetch   (inst_fetch),
    .data_fetch   (data_fetch),
    .alu_exec     (alu_exec),
    .write_back   (write_back),
    .pc_inc       (pc_inc),
    .nop_cycle    (nop_cycle),
    .halted       (halted),
    .retired      (retired)
  );

  typedef struct packed {
    logic [1:0]  q;
    logic        inst;
    logic        data;
    logic        alu;
    logic        wb;
    logic        pc;
    logic        nop;
    logic        hlt;
    logic [15:0] ret;
  } out_t;

  // One run-mode instruction cycle: inputs and the expected cycle outcome.
  typedef struct {
    logic        br;
    logic        sk;
    logic        run;
    logic        nop;
    logic [15:0] ret;
  } vec_t;

  vec_t vecs[11];
  out_t sb_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic out_t exp_ph(input int ph, input logic nop, input logic [15:0] ret);
    out_t e;
    e      = '0;
    e.q    = 2'(ph);
    e.inst = (ph == 0);
    e.data = (ph == 1) && !nop;
    e.alu  = (ph == 2) && !nop;
    e.wb   = (ph == 3) && !nop;
    e.pc   = (ph == 3);
    e.nop  = nop;
    e.ret  = ret;
    return e;
  endfunction

  function automatic out_t exp_idle(input logic hlt, input logic [15:0] ret);
    out_t e;
    e     = '0;
    e.hlt = hlt;
    e.ret = ret;
    return e;
  endfunction

  task automatic check(input string name, input out_t exp);
    out_t act;
    act = {q_phase, inst_fetch, data_fetch, alu_exec, write_back, pc_inc,
           nop_cycle, halted, retired};
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s @%0t: actual q=%0d if/df/ax/wb/pc=%b%b%b%b%b nop=%b halt=%b ret=%h, required q=%0d if/df/ax/wb/pc=%b%b%b%b%b nop=%b halt=%b ret=%h",
               name, $time, act.q, act.inst, act.data, act.alu, act.wb, act.pc,
               act.nop, act.hlt, act.ret, exp.q, exp.inst, exp.data, exp.alu,
               exp.wb, exp.pc, exp.nop, exp.hlt, exp.ret);
    end
  endtask

  task automatic step_cmp(input string name, input out_t exp);
    sb_q.push_back(exp);
    @(negedge clk);
    check(name, sb_q.pop_front());
  endtask

  // One instruction cycle: branch/skip presented for the Q3 edge, run_en
  // updated in Q2, step_req pulsed during phase step_ph (-1 = never).
  task automatic run_cycle(input string name, input logic br, input logic sk,
                           input logic runv, input logic nop,
                           input logic [15:0] ret, input int step_ph);
    for (int ph = 0; ph < 4; ph++) begin
      step_cmp($sformatf("%s_q%0d", name, ph + 1), exp_ph(ph, nop, ret));
      branch_taken = (ph == 2) ? br : 1'b0;
      skip_taken   = (ph == 2) ? sk : 1'b0;
      if (ph == 1) run_en = runv;
      step_req = (ph == step_ph);
    end
  endtask

  task automatic halt_wait(input string name, input int n, input logic [15:0] ret,
                           input logic step_end, input logic run_end);
    for (int i = 0; i < n; i++) begin
      step_cmp(name, exp_idle(1'b1, ret));
    end
    step_req = step_end;
    if (run_end) run_en = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // five plain cycles, branch, its flush (branch ignored), plain,
    // skip, its flush (skip ignored), last cycle with run_en dropped in Q2
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'd1};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'd2};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'd3};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'd4};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'd5};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 16'd6};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'd6};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'd7};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 16'd8};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd8};

    reset        = 1'b0;
    run_en       = 1'b0;
    step_req     = 1'b0;
    branch_taken = 1'b0;
    skip_taken   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", exp_idle(1'b0, 16'd0));

    // release: two WAIT clocks, then Q1 on the third edge
    reset  = 1'b1;
    run_en = 1'b1;
    step_cmp("wait1", exp_idle(1'b0, 16'd0));
    step_cmp("wait2", exp_idle(1'b0, 16'd0));

    for (int i = 0; i < 11; i++) begin
      run_cycle($sformatf("vec%0d", i), vecs[i].br, vecs[i].sk, vecs[i].run,
                vecs[i].nop, vecs[i].ret, -1);
    end

    // parked after the halt request; then one single step with a stray
    // second step_req in Q2
    halt_wait("halt_hold", 20, 16'd9, 1'b1, 1'b0);
    run_cycle("step", 1'b0, 1'b0, 1'b0, 1'b0, 16'd9, 1);
    halt_wait("step_done", 3, 16'd10, 1'b1, 1'b0);

    // branch in the stepped cycle, halt, then the next step is the flush
    run_cycle("br_step", 1'b1, 1'b0, 1'b0, 1'b0, 16'd10, -1);
    halt_wait("halt_flush_pend", 3, 16'd11, 1'b1, 1'b0);
    run_cycle("step_flush", 1'b0, 1'b0, 1'b0, 1'b1, 16'd11, -1);
    halt_wait("after_flush", 3, 16'd11, 1'b0, 1'b1);
    run_cycle("resume", 1'b0, 1'b0, 1'b1, 1'b0, 16'd11, -1);

    // asynchronous reset in the middle of Q3
    step_cmp("pre_rst_q1", exp_ph(0, 1'b0, 16'd12));
    step_cmp("pre_rst_q2", exp_ph(1, 1'b0, 16'd12));
    step_cmp("pre_rst_q3", exp_ph(2, 1'b0, 16'd12));
    #1 reset = 1'b0;
    #1 check("async_reset", exp_idle(1'b0, 16'd0));
    @(negedge clk);
    check("reset_hold", exp_idle(1'b0, 16'd0));
    reset = 1'b1;
    step_cmp("rewait1", exp_idle(1'b0, 16'd0));
    step_cmp("rewait2", exp_idle(1'b0, 16'd0));
    run_cycle("restart", 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, -1);
    halt_wait("restart_halt", 2, 16'd1, 1'b0, 1'b0);

    // counter preloaded to all-ones wraps to zero on the next retire
    force dut.u_retire.r_count = 16'hFFFF;
    #1;
    release dut.u_retire.r_count;
    halt_wait("preload", 1, 16'hFFFF, 1'b1, 1'b0);
    run_cycle("wrap", 1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF, -1);
    halt_wait("wrapped", 2, 16'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
